// File: rtl/dsp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined adder among num_req_p requesters; a tag FIFO routes results back in issue order.
// Optional DSP_ARB_STATS_EN adds saturating per-requester grant counters and a stall counter.
module dsp_add_arbiter #(
    parameter int width_p     = 32,
    parameter int num_req_p   = 4,
    parameter int tag_depth_p = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [num_req_p-1:0]           req_valid_i,
    output logic [num_req_p-1:0]           req_ready_o,
    input  logic [num_req_p*width_p-1:0]   req_a_i,
    input  logic [num_req_p*width_p-1:0]   req_b_i,
    output logic                           add_valid_o,
    input  logic                           add_ready_i,
    output logic [width_p-1:0]             add_a_o,
    output logic [width_p-1:0]             add_b_o,
    input  logic                           add_valid_i,
    output logic                           add_ready_o,
    input  logic [width_p:0]               add_c_i,
    output logic [num_req_p-1:0]           rsp_valid_o,
    input  logic [num_req_p-1:0]           rsp_ready_i,
    output logic [width_p:0]               rsp_c_o
`ifdef DSP_ARB_STATS_EN
    ,
    output logic [num_req_p*16-1:0]        stat_grant_o,
    output logic [15:0]                    stat_stall_o
`endif
);

    localparam int IdW  = $clog2(num_req_p);
    localparam int PtrW = $clog2(tag_depth_p);

    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  winner;
    logic            found;
    logic            tag_full, tag_empty;
    logic            issue, fire, ret;
    logic [IdW-1:0]  tag_mem_q [tag_depth_p];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic [IdW-1:0]  head;

    assign tag_full  = (count_q == (PtrW+1)'(tag_depth_p));
    assign tag_empty = (count_q == '0);

    always_comb begin
        logic [IdW-1:0] cand;
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = IdW'((int'(rr_ptr_q) + i) % num_req_p);
            if (!found && req_valid_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Reset gating keeps the issue side quiet while reset is held, even with requests pending.
    assign issue       = found & ~tag_full & reset_ni;
    assign add_valid_o = issue;
    assign fire        = issue & add_ready_i;
    assign add_a_o     = issue ? req_a_i[winner*width_p +: width_p] : '0;
    assign add_b_o     = issue ? req_b_i[winner*width_p +: width_p] : '0;
    assign rr_ptr_d    = (winner == IdW'(num_req_p - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (issue) begin
            req_ready_o[winner] = add_ready_i;
        end
    end

    assign head        = tag_mem_q[rd_ptr_q];
    assign add_ready_o = ~tag_empty & rsp_ready_i[head];
    assign ret         = add_valid_i & add_ready_o;
    assign rsp_c_o     = add_c_i;

    always_comb begin
        rsp_valid_o = '0;
        if (add_valid_i && !tag_empty) begin
            rsp_valid_o[head] = 1'b1;
        end
    end

    assign count_d = count_q + (PtrW+1)'(fire) - (PtrW+1)'(ret);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (fire) begin
                rr_ptr_q <= rr_ptr_d;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (ret) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (fire) begin
            tag_mem_q[wr_ptr_q] <= winner;
        end
    end

`ifdef DSP_ARB_STATS_EN
    logic [15:0] grant_cnt_q [num_req_p];
    logic [15:0] stall_cnt_q;
    logic        stall;

    assign stall = (issue & ~add_ready_i) | ((|req_valid_i) & tag_full);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < num_req_p; k++) begin
                grant_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < num_req_p; k++) begin
                if (fire && winner == IdW'(k) && grant_cnt_q[k] != 16'hFFFF) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
                end
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < num_req_p; g++) begin : g_stat
        assign stat_grant_o[g*16 +: 16] = grant_cnt_q[g];
    end
    assign stat_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_add_arbiter.sv
// Scoreboard bench for dsp_add_arbiter: a behavioural adder and round-robin model predict grants and in-order tagged results.
module tb_dsp_add_arbiter;
    localparam int W = 32;
    localparam int N = 4;
    localparam int D = 4;

    logic             clk = 1'b0;
    logic             reset_ni;
    logic [N-1:0]     req_valid_i;
    logic [N-1:0]     req_ready_o;
    logic [N*W-1:0]   req_a_i, req_b_i;
    logic             add_valid_o, add_ready_i;
    logic [W-1:0]     add_a_o, add_b_o;
    logic             add_valid_i, add_ready_o;
    logic [W:0]       add_c_i;
    logic [N-1:0]     rsp_valid_o, rsp_ready_i;
    logic [W:0]       rsp_c_o;

    dsp_add_arbiter #(.width_p(W), .num_req_p(N), .tag_depth_p(D)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .add_valid_o(add_valid_o), .add_ready_i(add_ready_i),
        .add_a_o(add_a_o), .add_b_o(add_b_o),
        .add_valid_i(add_valid_i), .add_ready_o(add_ready_o), .add_c_i(add_c_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_c_o(rsp_c_o)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [W:0] c; } exp_t;
    typedef struct { logic [W:0] c; int rc; } pipe_t;

    exp_t        sb[$];
    pipe_t       pipe[$];
    logic [W-1:0] a_op [N];
    logic [W-1:0] b_op [N];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, occ = 0, rr = 0, last_rc = 0;
    bit ret_flag = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic [N-1:0] v, input bit ar, input logic [N-1:0] rdy);
        @(negedge clk);
        cyc++;
        req_valid_i = v;
        add_ready_i = ar;
        rsp_ready_i = rdy;
        for (int k = 0; k < N; k++) begin
            req_a_i[k*W +: W] = a_op[k];
            req_b_i[k*W +: W] = b_op[k];
        end
        add_valid_i = 1'b0;
        add_c_i     = '0;
        if (pipe.size() > 0 && pipe[0].rc <= cyc) begin
            add_valid_i = 1'b1;
            add_c_i     = pipe[0].c;
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            a_op[k] = $urandom;
            b_op[k] = $urandom;
        end
    endtask

    // Return-side monitor: checks routing of the adder result against the head of the expected queue.
    always @(negedge clk) begin
        logic [N-1:0] exp_v;
        bit           exp_rdy;
        #1;
        ret_flag = 0;
        if (reset_ni) begin
            exp_v   = '0;
            exp_rdy = 0;
            if (sb.size() > 0) begin
                exp_rdy = rsp_ready_i[sb[0].id];
                if (add_valid_i) exp_v[sb[0].id] = 1'b1;
            end
            chk("rsp_valid_o", rsp_valid_o, exp_v);
            chk("add_ready_o", add_ready_o, exp_rdy);
            if (add_valid_i && add_ready_o && sb.size() > 0) begin
                chk("rsp_c_o", rsp_c_o, sb[0].c);
                void'(sb.pop_front());
                void'(pipe.pop_front());
                ret_flag = 1;
            end
        end
    end

    // Issue-side monitor: round-robin reference model, pushes expected results on each fire.
    always @(negedge clk) begin
        int          w;
        bit          any, fire;
        logic [N-1:0] exp_r;
        logic [W-1:0] ea, eb;
        pipe_t       pe;
        exp_t        se;
        #2;
        if (reset_ni) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int id;
                id = (rr + k) % N;
                if (w < 0 && req_valid_i[id]) w = id;
            end
            any  = (w >= 0) && (occ < D);
            fire = any && add_ready_i;
            exp_r = '0;
            ea = '0;
            eb = '0;
            if (any) begin
                ea = req_a_i[w*W +: W];
                eb = req_b_i[w*W +: W];
                if (add_ready_i) exp_r[w] = 1'b1;
            end
            chk("add_valid_o", add_valid_o, any);
            chk("req_ready_o", req_ready_o, exp_r);
            chk("add_a_o", add_a_o, ea);
            chk("add_b_o", add_b_o, eb);
            if (fire) begin
                se.id = w;
                se.c  = {1'b0, ea} + {1'b0, eb};
                sb.push_back(se);
                pe.c  = {1'b0, add_a_o} + {1'b0, add_b_o};
                pe.rc = cyc + int'($urandom_range(1, 4));
                if (pe.rc < last_rc) pe.rc = last_rc;
                last_rc = pe.rc;
                pipe.push_back(pe);
                rr = (w + 1) % N;
            end
            occ = occ + int'(fire) - int'(ret_flag);
        end
    end

    initial begin
        reset_ni    = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        add_ready_i = 1'b0;
        add_valid_i = 1'b0;
        add_c_i     = '0;
        rsp_ready_i = '0;
        for (int k = 0; k < N; k++) begin
            a_op[k] = '0;
            b_op[k] = '0;
        end

        @(negedge clk);
        #1;
        chk("reset add_valid_o", add_valid_o, 1'b0);
        chk("reset req_ready_o", req_ready_o, '0);
        chk("reset rsp_valid_o", rsp_valid_o, '0);
        chk("reset add_ready_o", add_ready_o, 1'b0);
        @(negedge clk);
        reset_ni = 1'b1;

        // Requester 1 alone: 5 + 7.
        a_op[1] = 32'd5;
        b_op[1] = 32'd7;
        step(4'b0010, 1'b1, 4'hF);
        repeat (8) step(4'b0000, 1'b1, 4'hF);

        // All requesters valid: rotating grants.
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            step(4'b1111, 1'b1, 4'hF);
        end
        repeat (8) step(4'b0000, 1'b1, 4'hF);

        // Carry out of the top bit.
        a_op[3] = 32'hFFFF_FFFF;
        b_op[3] = 32'hFFFF_FFFF;
        step(4'b1000, 1'b1, 4'hF);
        repeat (8) step(4'b0000, 1'b1, 4'hF);

        // Results blocked: tag FIFO fills, then drains in order and issue resumes.
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            step(4'b1111, 1'b1, 4'h0);
        end
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            step(4'b1111, 1'b1, 4'hF);
        end
        repeat (8) step(4'b0000, 1'b1, 4'hF);

        // Adder stall with requester 2 pending.
        a_op[2] = 32'h1234_5678;
        b_op[2] = 32'h0000_1111;
        repeat (3) step(4'b0100, 1'b0, 4'hF);
        step(4'b0100, 1'b1, 4'hF);
        repeat (8) step(4'b0000, 1'b1, 4'hF);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            step(N'($urandom), ($urandom_range(0, 3) != 0), N'($urandom | $urandom));
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            step(4'b1111, 1'b1, N'($urandom));
        end
        #3;
        reset_ni = 1'b0;
        #1;
        chk("midreset add_valid_o", add_valid_o, 1'b0);
        chk("midreset req_ready_o", req_ready_o, '0);
        chk("midreset rsp_valid_o", rsp_valid_o, '0);
        chk("midreset add_ready_o", add_ready_o, 1'b0);
        sb.delete();
        pipe.delete();
        occ     = 0;
        rr      = 0;
        last_rc = 0;
        @(posedge clk);
        rand_ops();
        step(4'b1010, 1'b1, 4'hF);
        reset_ni = 1'b1;
        #3;
        chk("post-reset first grant", req_ready_o, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            step(4'b1010, 1'b1, 4'hF);
        end

        for (int i = 0; i < 200 && (sb.size() > 0 || pipe.size() > 0); i++) begin
            step(4'b0000, 1'b1, 4'hF);
        end
        step(4'b0000, 1'b1, 4'hF);
        chk("drain outstanding", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
